vertex_xform: RTL and testbench
===============================

// Module: vertex_xform
// PURPOSE
// - Stage 1.5 of the raster pipeline: affine-transforms the four vertices of one geometry-memory primitive word.
// - Clamps the results to the 320x240 screen and hands the repacked word to the row rasteriser.
// - Sits between geometry memory (gmem_dout) and the raster pipeline's stage-1 vertex registers.
// - Replaces the software (MicroBlaze) transform.
// - Processes one vertex per cycle through a single shared 2x2 multiply-accumulate datapath.
// PARAMETERS
// - SCREEN_W  320  x clamp upper bound is SCREEN_W-1
// - SCREEN_H  240  y clamp upper bound is SCREEN_H-1
// - FRAC        8  fractional bits of matrix coefficients (Q8.8)
// PORTS
// - Clk          in   1    system clock (same domain as geometry memory write side)
// - Reset_n      in   1    asynchronous, active-low reset
// - in_valid     in   1    in_prim holds a primitive
// - in_ready     out  1    block can accept a primitive
// - in_prim      in   256  vertex k: x=[32k+8:32k], y=[32k+24:32k+16], k=0..3; color etc. in [255:128]
// - m00,m01,m10,m11 in 16 signed Q8.8 matrix coefficients
// - tx, ty       in   16   signed integer translation
// - out_valid    out  1    out_prim/out_cull valid
// - out_ready    in   1    downstream accepts
// - out_prim     out  256  transformed primitive, same packing as in_prim
// - out_cull     out  1    all four pre-clamp vertices wholly off one screen edge
// - xform_count  out  16   count of primitives transferred out; wraps
// BEHAVIOUR
// - Reset (async, Reset_n=0):
//   - state=IDLE; in_ready=0; out_valid=0; out_prim=0; out_cull=0; xform_count=0.
//   - in_ready is registered and rises on the first Clk edge after reset release.
// - FSM: IDLE -> XFORM -> OUT -> IDLE. in_ready=1 only in IDLE.
//   - IDLE: on edge t0 with in_valid&&in_ready:
//     - latch in_prim, m00..m11, tx, ty into shadow regs;
//     - clear cull accumulators; vidx=0; go XFORM.
//     - Input changes after t0 have no effect on this primitive.
//   - XFORM: edge t0+1+k computes vertex k (k=0..3).
//     - After edge t0+4: out_valid=1, state=OUT.
//   - OUT: out_prim and out_cull held stable while out_valid && !out_ready.
//     - On the edge with out_ready=1: out_valid=0, xform_count+=1, state=IDLE, in_ready=1 after that edge.
//   - No bypass: at most one primitive every 6 cycles.
// - Arithmetic:
//   - x, y zero-extended to signed 10 bits.
//   - px = (m00*x + m01*y) >>> FRAC, then + sext(tx).
//   - py = (m10*x + m11*y) >>> FRAC, then + sext(ty).
//   - Products 26 bits; sums 27 bits, no overflow.
//   - >>> is arithmetic, i.e. floor, so -0.5 becomes -1.
// - Clamp: px<0 -> 0; px>SCREEN_W-1 -> SCREEN_W-1. Same rule for py with SCREEN_H.
//   - Written to x/y lanes; bits [32k+15:32k+9] and [32k+31:32k+25] output 0.
// - Upper half: out_prim[255:128] = latched in_prim[255:128] unchanged.
// - Cull: four sticky AND flags across the 4 pre-clamp vertices:
//   - all px<0; all px>W-1; all py<0; all py>H-1.
//   - out_cull = OR of the four flags.
//   - Primitive is still emitted; the consumer decides whether to drop it.
// - Boundaries:
//   - in_valid during XFORM/OUT is ignored (in_ready=0) and must be held by the source.
//   - xform_count 0xFFFF+1 -> 0x0000.
//   - Reset mid-XFORM or mid-OUT: primitive discarded, nothing emitted, no count.
// TESTING
// - Identity (m00=m11=0x0100, others 0, t=0), v0=(10,20), out_ready=1:
//   - accept at t0 -> out_valid after t0+4; v0=(10,20); color bits passed; out_cull=0.
// - Scale 2 (m00=m11=0x0200), v=(200,100) -> (319,200) clamped; v=(0,0) -> (0,0).
// - tx=-50 (0xFFCE), all vertices x<50 -> all x=0, out_cull=1.
//   - Same with one vertex x=60 -> x=10, out_cull=0.
// - Rotate 90 (m01=0xFF00, m10=0x0100, tx=239), v=(5,7) -> x=-7+239=232, y=5.
// - Backpressure: out_ready=0 for 10 cycles -> out_prim stable, in_ready=0, count unchanged; release -> count+1.
//   - Matrix changed after accept -> output still uses the latched matrix.
// - Reset_n pulsed low at t0+2 -> out_valid stays 0, count 0, in_ready high 1 edge after release.
//   - 0x10000 transfers -> xform_count wraps to 0.

Source files
------------

// File: rtl/vertex_xform.sv
// Affine transform of the four vertices of one primitive word through a shared
// 2x2 multiply-accumulate, with screen clamping and trivial-cull flagging.
module vertex_xform #(
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 240,
  parameter int unsigned FRAC     = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_prim,
  input  logic [15:0]  m00,
  input  logic [15:0]  m01,
  input  logic [15:0]  m10,
  input  logic [15:0]  m11,
  input  logic [15:0]  tx,
  input  logic [15:0]  ty,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_prim,
  output logic         out_cull,
  output logic [15:0]  xform_count
);

  localparam int unsigned CW = 9;
  localparam int unsigned MW = 16;
  localparam int unsigned PW = 26;
  localparam int unsigned SW = 27;
  localparam int unsigned RW = 28;
  localparam logic signed [RW-1:0] L_XMAX = RW'(SCREEN_W - 1);
  localparam logic signed [RW-1:0] L_YMAX = RW'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, XFORM, OUT} state_t;

  state_t                r_state;
  logic [3:0][CW-1:0]    r_vx;
  logic [3:0][CW-1:0]    r_vy;
  logic signed [MW-1:0]  r_m00, r_m01, r_m10, r_m11, r_tx, r_ty;
  logic [1:0]            r_vidx;
  logic                  r_f_xl, r_f_xr, r_f_yt, r_f_yb;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [255:0]          r_out_prim;
  logic                  r_out_cull;
  logic [15:0]           r_count;

  logic signed [9:0]     w_x10, w_y10;
  logic signed [PW-1:0]  w_x26, w_y26;
  logic signed [PW-1:0]  w_m00e, w_m01e, w_m10e, w_m11e;
  logic signed [PW-1:0]  w_p00, w_p01, w_p10, w_p11;
  logic signed [SW-1:0]  w_sumx, w_sumy;
  logic signed [RW-1:0]  w_px, w_py;
  logic                  w_x_neg, w_x_hi, w_y_neg, w_y_hi;
  logic [CW-1:0]         w_cx, w_cy;
  logic [31:0]           w_lane;
  logic                  w_f_xl, w_f_xr, w_f_yt, w_f_yb;
  logic                  w_unused_pad;

  assign w_unused_pad = ^{in_prim[15:9],   in_prim[31:25],  in_prim[47:41],
                          in_prim[63:57],  in_prim[79:73],  in_prim[95:89],
                          in_prim[111:105], in_prim[127:121]};

  // Shared MAC: coordinates are unsigned 9-bit, widened before multiplying
  assign w_x10  = {1'b0, r_vx[r_vidx]};
  assign w_y10  = {1'b0, r_vy[r_vidx]};
  assign w_x26  = PW'(w_x10);
  assign w_y26  = PW'(w_y10);
  assign w_m00e = PW'(r_m00);
  assign w_m01e = PW'(r_m01);
  assign w_m10e = PW'(r_m10);
  assign w_m11e = PW'(r_m11);
  assign w_p00  = w_m00e * w_x26;
  assign w_p01  = w_m01e * w_y26;
  assign w_p10  = w_m10e * w_x26;
  assign w_p11  = w_m11e * w_y26;
  assign w_sumx = SW'(w_p00) + SW'(w_p01);
  assign w_sumy = SW'(w_p10) + SW'(w_p11);
  assign w_px   = RW'(w_sumx >>> FRAC) + RW'(r_tx);
  assign w_py   = RW'(w_sumy >>> FRAC) + RW'(r_ty);

  assign w_x_neg = w_px[RW-1];
  assign w_y_neg = w_py[RW-1];
  assign w_x_hi  = w_px > L_XMAX;
  assign w_y_hi  = w_py > L_YMAX;

  assign w_cx = w_x_neg ? '0 : (w_x_hi ? CW'(SCREEN_W - 1) : w_px[CW-1:0]);
  assign w_cy = w_y_neg ? '0 : (w_y_hi ? CW'(SCREEN_H - 1) : w_py[CW-1:0]);
  assign w_lane = {7'b0, w_cy, 7'b0, w_cx};

  // Cull flags stay set only while every vertex so far is off the same edge
  assign w_f_xl = r_f_xl & w_x_neg;
  assign w_f_xr = r_f_xr & w_x_hi;
  assign w_f_yt = r_f_yt & w_y_neg;
  assign w_f_yb = r_f_yb & w_y_hi;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_vx        <= '0;
      r_vy        <= '0;
      r_m00       <= '0;
      r_m01       <= '0;
      r_m10       <= '0;
      r_m11       <= '0;
      r_tx        <= '0;
      r_ty        <= '0;
      r_vidx      <= '0;
      r_f_xl      <= 1'b0;
      r_f_xr      <= 1'b0;
      r_f_yt      <= 1'b0;
      r_f_yb      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_prim  <= '0;
      r_out_cull  <= 1'b0;
      r_count     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            for (int k = 0; k < 4; k++) begin
              r_vx[k] <= in_prim[32*k +: CW];
              r_vy[k] <= in_prim[32*k+16 +: CW];
            end
            r_m00      <= m00;
            r_m01      <= m01;
            r_m10      <= m10;
            r_m11      <= m11;
            r_tx       <= tx;
            r_ty       <= ty;
            r_f_xl     <= 1'b1;
            r_f_xr     <= 1'b1;
            r_f_yt     <= 1'b1;
            r_f_yb     <= 1'b1;
            r_vidx     <= '0;
            r_out_prim <= {in_prim[255:128], 128'b0};
            r_in_ready <= 1'b0;
            r_state    <= XFORM;
          end
        end
        XFORM: begin
          r_out_prim[{r_vidx, 5'd0} +: 32] <= w_lane;
          r_f_xl <= w_f_xl;
          r_f_xr <= w_f_xr;
          r_f_yt <= w_f_yt;
          r_f_yb <= w_f_yb;
          r_vidx <= r_vidx + 2'd1;
          if (r_vidx == 2'd3) begin
            r_out_valid <= 1'b1;
            r_out_cull  <= w_f_xl | w_f_xr | w_f_yt | w_f_yb;
            r_state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_count     <= r_count + 16'd1;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_prim    = r_out_prim;
  assign out_cull    = r_out_cull;
  assign xform_count = r_count;

endmodule

// File: tb/tb_vertex_xform.sv
// Scoreboard bench for vertex_xform: directed primitives with hand-computed results.
module tb_vertex_xform;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_prim;
  logic [15:0]  m00, m01, m10, m11, tx, ty;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_prim;
  logic         out_cull;
  logic [15:0]  xform_count;

  typedef struct packed {
    logic [255:0] prim;
    logic         cull;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   mon_cnt = 0;

  localparam logic [15:0] ID = 16'h0100;
  localparam logic [127:0] U1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] U2 = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_5555_AAAA;

  vertex_xform dut (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_prim(in_prim), .m00(m00), .m01(m01), .m10(m10), .m11(m11),
    .tx(tx), .ty(ty), .out_valid(out_valid), .out_ready(out_ready),
    .out_prim(out_prim), .out_cull(out_cull), .xform_count(xform_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane(input logic [6:0] f, input int x, input int y);
    return {f, 9'(y), f, 9'(x)};
  endfunction

  function automatic logic [255:0] mk(input logic [127:0] u, input bit j,
                                      input int x0, input int y0, input int x1, input int y1,
                                      input int x2, input int y2, input int x3, input int y3);
    logic [6:0] f;
    f = j ? 7'h7F : 7'h00;
    return {u, lane(f, x3, y3), lane(f, x2, y2), lane(f, x1, y1), lane(f, x0, y0)};
  endfunction

  // Offers one primitive; returns #1 after the accepting edge with inputs scrambled
  task automatic send(input logic [255:0] p, input logic [15:0] a00, input logic [15:0] a01,
                      input logic [15:0] a10, input logic [15:0] a11,
                      input logic [15:0] t_x, input logic [15:0] t_y,
                      input logic [255:0] ep, input logic ec, input bit push);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(posedge Clk); #1;
      k++;
    end
    if (in_ready !== 1'b1) chk("in_ready_timeout", {255'b0, in_ready}, 256'd1);
    in_prim = p; m00 = a00; m01 = a01; m10 = a10; m11 = a11; tx = t_x; ty = t_y;
    in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    in_prim = ~p; m00 = 16'h7FFF; m01 = 16'h1234; m10 = 16'h8001; m11 = 16'h0F0F;
    tx = 16'd1234; ty = 16'hFACE;
    if (push) q.push_back('{prim: ep, cull: ec});
  endtask

  // Monitor: compares every handshake against the scoreboard, then the counter
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        chk("in_ready_during_out", {255'b0, in_ready}, 256'd0);
        if (q.size() == 0) begin
          chk("unexpected_output", {255'b0, out_valid}, 256'd0);
        end else begin
          e = q.pop_front();
          chk("out_prim", out_prim, e.prim);
          chk("out_cull", {255'b0, out_cull}, {255'b0, e.cull});
          mon_cnt++;
        end
        @(posedge Clk); #1;
        chk("xform_count", {240'b0, xform_count}, 256'(mon_cnt));
      end
    end
  end

  initial begin
    logic [255:0] ep;
    int k;
    Reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_prim = '0;
    m00 = '0; m01 = '0; m10 = '0; m11 = '0; tx = '0; ty = '0;
    repeat (2) @(posedge Clk); #1;
    chk("rst_in_ready", {255'b0, in_ready}, 256'd0);
    chk("rst_out_valid", {255'b0, out_valid}, 256'd0);
    chk("rst_out_prim", out_prim, 256'd0);
    chk("rst_out_cull", {255'b0, out_cull}, 256'd0);
    chk("rst_count", {240'b0, xform_count}, 256'd0);
    Reset_n = 1'b1;
    chk("in_ready_before_edge", {255'b0, in_ready}, 256'd0);
    @(posedge Clk); #1;
    chk("in_ready_after_edge", {255'b0, in_ready}, 256'd1);

    // Reset pulsed two edges into XFORM: primitive must vanish
    send(mk(U1, 0, 1, 2, 3, 4, 5, 6, 7, 8), ID, 0, 0, ID, 0, 0, '0, 1'b0, 1'b0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset_n = 1'b0;
    #2;
    chk("midrst_out_valid", {255'b0, out_valid}, 256'd0);
    chk("midrst_in_ready", {255'b0, in_ready}, 256'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    chk("midrst_ready_low", {255'b0, in_ready}, 256'd0);
    @(posedge Clk); #1;
    chk("midrst_ready_high", {255'b0, in_ready}, 256'd1);
    repeat (8) @(posedge Clk); #1;
    chk("midrst_no_output", {255'b0, out_valid}, 256'd0);
    chk("midrst_count", {240'b0, xform_count}, 256'd0);

    // Identity with pad bits set in the input; also checks output latency
    send(mk(U1, 1, 10, 20, 0, 0, 319, 239, 100, 50), ID, 0, 0, ID, 0, 0,
         mk(U1, 0, 10, 20, 0, 0, 319, 239, 100, 50), 1'b0, 1'b1);
    repeat (3) @(posedge Clk); #1;
    chk("latency_t0p3", {255'b0, out_valid}, 256'd0);
    @(posedge Clk); #1;
    chk("latency_t0p4", {255'b0, out_valid}, 256'd1);

    send(mk(U2, 0, 200, 100, 0, 0, 10, 119, 160, 120), 16'h0200, 0, 0, 16'h0200, 0, 0,
         mk(U2, 0, 319, 200, 0, 0, 20, 238, 319, 239), 1'b0, 1'b1);
    send(mk(U1, 0, 10, 5, 20, 6, 30, 7, 49, 8), ID, 0, 0, ID, 16'hFFCE, 0,
         mk(U1, 0, 0, 5, 0, 6, 0, 7, 0, 8), 1'b1, 1'b1);
    send(mk(U1, 0, 10, 5, 20, 6, 30, 7, 60, 8), ID, 0, 0, ID, 16'hFFCE, 0,
         mk(U1, 0, 0, 5, 0, 6, 0, 7, 10, 8), 1'b0, 1'b1);
    send(mk(U2, 0, 5, 7, 0, 0, 100, 200, 300, 10), 0, 16'hFF00, ID, 0, 16'd239, 0,
         mk(U2, 0, 232, 5, 239, 0, 39, 100, 229, 239), 1'b0, 1'b1);
    // Negative halves must floor, not truncate
    send(mk(U1, 0, 1, 3, 3, 5, 0, 0, 100, 479), 16'hFF80, 0, 0, 16'h0080, 16'd10, 0,
         mk(U1, 0, 9, 1, 8, 2, 10, 0, 0, 239), 1'b0, 1'b1);
    send(mk(U2, 0, 1, 0, 2, 0, 3, 0, 4, 0), ID, 0, 0, ID, 0, 16'd300,
         mk(U2, 0, 1, 239, 2, 239, 3, 239, 4, 239), 1'b1, 1'b1);

    // Backpressure: output held stable, no count, no new accept
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(posedge Clk); #1;
      k++;
    end
    out_ready = 1'b0;
    ep = mk(U1, 0, 12, 3, 5, 0, 319, 239, 55, 55);
    send(mk(U1, 1, 7, 8, 0, 3, 314, 244, 50, 60), ID, 0, 0, ID, 16'd5, 16'hFFFB,
         ep, 1'b0, 1'b1);
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      @(posedge Clk); #1;
      k++;
    end
    chk("bp_out_valid", {255'b0, out_valid}, 256'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      chk("bp_prim_stable", out_prim, ep);
      chk("bp_in_ready", {255'b0, in_ready}, 256'd0);
      chk("bp_count", {240'b0, xform_count}, 256'd7);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;

    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(posedge Clk); #1;
      k++;
    end
    chk("scoreboard_drained", 256'(q.size()), 256'd0);
    repeat (4) @(posedge Clk); #1;
    chk("final_count", {240'b0, xform_count}, 256'd8);
    chk("final_in_ready", {255'b0, in_ready}, 256'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
